// File: rtl/ddfs_pkg.sv
// Shared DDFS definitions: frequency word width, sweep FSM states
// and the latched sweep configuration bundle.
package ddfs_pkg;

    localparam int FW      = 23;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic [FW-1:0]      f_start;
        logic [FW-1:0]      f_stop;
        logic [FW-1:0]      f_step;
        logic [DWELL_W-1:0] dwell;
        logic               mode;
    } sweep_cfg_t;

endpackage

// File: rtl/ddfs_dwell_timer.sv
// Dwell down-counter: load reloads, en decrements to zero and parks.
// Ports: clk, rst (sync high), load, en, reload -> zero.
module ddfs_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] reload,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Linear chirp generator feeding ddfs.fcontrol (single-shot or triangle).
// Ports: clk, rst, start, stop, mode, f_start/f_stop/f_step, dwell -> fcontrol, busy, done.
module ddfs_sweep_ctrl
    import ddfs_pkg::*;
#(
    parameter int FW      = ddfs_pkg::FW,
    parameter int DWELL_W = ddfs_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [FW-1:0]      f_start,
    input  logic [FW-1:0]      f_stop,
    input  logic [FW-1:0]      f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FW-1:0]      fcontrol,
    output logic               busy,
    output logic               done
);

    sweep_state_t state;
    sweep_cfg_t   cfg;
    logic         pending;
    logic         zero;
    logic         load;

    logic [FW:0]   sum;
    logic [FW:0]   diff;
    logic [FW-1:0] up_val;
    logic [FW-1:0] dn_val;

    // One extra bit: carry/borrow means the true result is out of range.
    always_comb begin
        sum  = {1'b0, fcontrol} + {1'b0, cfg.f_step};
        diff = {1'b0, fcontrol} - {1'b0, cfg.f_step};
        up_val = sum[FW-1:0];
        dn_val = diff[FW-1:0];
        if (sum[FW] || sum[FW-1:0] > cfg.f_stop) begin
            up_val = cfg.f_stop;
        end
        if (diff[FW] || diff[FW-1:0] < cfg.f_start) begin
            dn_val = cfg.f_start;
        end
    end

    // Reload on sweep launch and on every frequency step.
    assign load = !stop &&
                  ((state == IDLE && pending) ||
                   (state != IDLE && zero));

    ddfs_dwell_timer #(
        .W(DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .en    (state != IDLE),
        .reload(cfg.dwell),
        .zero  (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cfg      <= '0;
            pending  <= 1'b0;
            fcontrol <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (stop) begin
                        pending <= 1'b0;
                    end else if (pending) begin
                        pending  <= 1'b0;
                        fcontrol <= cfg.f_start;
                        state    <= UP;
                        busy     <= 1'b1;
                    end else if (start) begin
                        pending     <= 1'b1;
                        cfg.f_start <= f_start;
                        cfg.f_stop  <= f_stop;
                        cfg.f_step  <= f_step;
                        cfg.dwell   <= dwell;
                        // Degenerate range cannot bounce; run it once.
                        cfg.mode    <= mode && (f_stop > f_start);
                    end
                end
                UP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (zero) begin
                        if (fcontrol >= cfg.f_stop) begin
                            if (cfg.mode) begin
                                state    <= DOWN;
                                fcontrol <= dn_val;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            fcontrol <= up_val;
                        end
                    end
                end
                DOWN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (zero) begin
                        if (fcontrol <= cfg.f_start) begin
                            state    <= UP;
                            fcontrol <= up_val;
                        end else begin
                            fcontrol <= dn_val;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed testbench for ddfs_sweep_ctrl.
// Each task drives one scenario and checks against hand-computed values.
module tb_ddfs_sweep_ctrl;

    localparam int FW = 23;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          mode;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic [FW-1:0] fcontrol;
    logic          busy;
    logic          done;

    int pass_cnt = 0;
    int total    = 0;

    ddfs_sweep_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .f_start (f_start),
        .f_stop  (f_stop),
        .f_step  (f_step),
        .dwell   (dwell),
        .fcontrol(fcontrol),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                            input logic [FW-1:0] st, input logic [DW-1:0] dw,
                            input logic md);
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        mode    = md;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; stop = 0; mode = 0;
        f_start = 0; f_stop = 0; f_step = 0; dwell = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++;
        if (fcontrol !== '0) $display("FAIL reset_fcontrol got %0h want 0", fcontrol);
        else pass_cnt++;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_single_shot();
        logic [FW-1:0] exp_v [4] = '{100, 110, 120, 130};
        f_start = 100; f_stop = 130; f_step = 10; dwell = 2; mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || fcontrol !== 0)
            $display("FAIL ss_latency got busy=%b fc=%0d want 0 0", busy, fcontrol);
        else pass_cnt++;
        tick();
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (fcontrol !== exp_v[v] || done !== 1'b0 || busy !== 1'b1)
                    $display("FAIL ss_seq[%0d.%0d] got fc=%0d d=%b b=%b want %0d 0 1",
                             v, k, fcontrol, done, busy, exp_v[v]);
                else pass_cnt++;
                tick();
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || fcontrol !== 130)
            $display("FAIL ss_done got d=%b b=%b fc=%0d want 1 0 130", done, busy, fcontrol);
        else pass_cnt++;
        tick();
        total++;
        if (done !== 1'b0 || fcontrol !== 130)
            $display("FAIL ss_after got d=%b fc=%0d want 0 130", done, fcontrol);
        else pass_cnt++;
    endtask

    task automatic test_clamp();
        logic [FW-1:0] exp_v [4] = '{100, 110, 120, 125};
        do_start(100, 125, 10, 0, 1'b0);
        for (int v = 0; v < 4; v++) begin
            total++;
            if (fcontrol !== exp_v[v] || done !== 1'b0)
                $display("FAIL clamp_seq[%0d] got fc=%0d d=%b want %0d 0",
                         v, fcontrol, done, exp_v[v]);
            else pass_cnt++;
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || fcontrol !== 125)
            $display("FAIL clamp_done got d=%b b=%b fc=%0d want 1 0 125", done, busy, fcontrol);
        else pass_cnt++;
    endtask

    task automatic test_triangle();
        logic [FW-1:0] exp_v [9] = '{10, 20, 30, 20, 10, 20, 30, 20, 10};
        do_start(10, 30, 10, 0, 1'b1);
        for (int v = 0; v < 9; v++) begin
            total++;
            if (fcontrol !== exp_v[v] || done !== 1'b0 || busy !== 1'b1)
                $display("FAIL tri_seq[%0d] got fc=%0d d=%b b=%b want %0d 0 1",
                         v, fcontrol, done, busy, exp_v[v]);
            else pass_cnt++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || fcontrol !== 20)
            $display("FAIL tri_stop got b=%b d=%b fc=%0d want 0 0 20", busy, done, fcontrol);
        else pass_cnt++;
    endtask

    task automatic test_stop_restart();
        do_start(100, 200, 10, 1, 1'b0);
        tick(); tick();
        total++;
        if (fcontrol !== 110) $display("FAIL stop_pre got fc=%0d want 110", fcontrol);
        else pass_cnt++;
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || fcontrol !== 110)
            $display("FAIL stop_idle got b=%b d=%b fc=%0d want 0 0 110", busy, done, fcontrol);
        else pass_cnt++;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || fcontrol !== 110)
            $display("FAIL stop_hold got b=%b d=%b fc=%0d want 0 0 110", busy, done, fcontrol);
        else pass_cnt++;
        do_start(100, 200, 10, 1, 1'b0);
        total++;
        if (busy !== 1'b1 || fcontrol !== 100)
            $display("FAIL restart got b=%b fc=%0d want 1 100", busy, fcontrol);
        else pass_cnt++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        f_start = 5; f_stop = 50; f_step = 5; dwell = 0; mode = 0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || fcontrol !== 100)
            $display("FAIL startstop got b=%b fc=%0d want 0 100", busy, fcontrol);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_start(23'h7FFFF0, 23'h7FFFFF, 23'h20, 0, 1'b0);
        total++;
        if (fcontrol !== 23'h7FFFF0) $display("FAIL ovf_0 got %0h want 7ffff0", fcontrol);
        else pass_cnt++;
        tick();
        total++;
        if (fcontrol !== 23'h7FFFFF || done !== 1'b0)
            $display("FAIL ovf_1 got fc=%0h d=%b want 7fffff 0", fcontrol, done);
        else pass_cnt++;
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || fcontrol !== 23'h7FFFFF)
            $display("FAIL ovf_done got d=%b b=%b fc=%0h want 1 0 7fffff", done, busy, fcontrol);
        else pass_cnt++;
    endtask

    task automatic test_step_zero();
        do_start(40, 80, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (fcontrol !== 40 || busy !== 1'b1)
                $display("FAIL step0[%0d] got fc=%0d b=%b want 40 1", i, fcontrol, busy);
            else pass_cnt++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_degenerate();
        do_start(50, 50, 10, 3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (fcontrol !== 50 || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL degen[%0d] got fc=%0d b=%b d=%b want 50 1 0",
                         i, fcontrol, busy, done);
            else pass_cnt++;
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL degen_done got d=%b b=%b want 1 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_start(10, 30, 10, 0, 1'b1);
        tick(); tick(); tick();
        total++;
        if (fcontrol !== 20 || busy !== 1'b1)
            $display("FAIL rstmid_pre got fc=%0d b=%b want 20 1", fcontrol, busy);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (fcontrol !== 0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rstmid got fc=%0d b=%b d=%b want 0 0 0", fcontrol, busy, done);
        else pass_cnt++;
        tick(); tick();
        total++;
        if (fcontrol !== 0 || busy !== 1'b0)
            $display("FAIL rstmid_hold got fc=%0d b=%b want 0 0", fcontrol, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_clamp();
        test_triangle();
        test_stop_restart();
        test_start_stop_idle();
        test_overflow();
        test_step_zero();
        test_degenerate();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
